osc_window_monitor: RTL and testbench

- Clocked, multi-channel successor to the combinational feedback-loop oscillation check.
- Samples NUM_CH feedback nets every cycle and counts toggles per channel over a fixed window.
- Flags any channel whose toggle count reaches a threshold, and drives a per-channel loop-break enable to open the offending feedback path.
- Sits beside the combinational logic clusters; brk outputs gate the feedback AND terms.

---
 rtl/osc_mon_pkg.sv | 32 +++
 rtl/osc_ch_counter.sv | 40 ++++
 rtl/osc_window_monitor.sv | 107 ++++++++++
 tb/tb_osc_window_monitor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/osc_mon_pkg.sv
// Shared types and width helpers for the windowed oscillation monitor.
package osc_mon_pkg;

  localparam int TRIP_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_MONITOR = 3'd2,
    ST_HOLD    = 3'd3,
    ST_LOCK    = 3'd4
  } state_e;

  // Bits needed for a counter covering 0..n-1 (never less than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int win_cnt_w(input int win_len);
    return cnt_w(win_len);
  endfunction

  function automatic int hold_cnt_w(input int hold_len);
    return cnt_w(hold_len);
  endfunction

  // Toggle counter must hold 0..thresh inclusive.
  function automatic int tog_cnt_w(input int thresh);
    return cnt_w(thresh + 1);
  endfunction

endpackage

// File: rtl/osc_ch_counter.sv
// One monitored net: previous-sample register, toggle detect, saturating toggle count.
module osc_ch_counter
  import osc_mon_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int CW     = tog_cnt_w(THRESH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic prime,
  input  logic eval,
  input  logic last,
  input  logic sig,
  output logic trip
);

  logic          prev;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tog;

  assign tog     = sig ^ prev;
  assign cnt_nxt = (tog && cnt != CW'(THRESH)) ? cnt + CW'(1) : cnt;
  // Count saturates at THRESH, so equality is the same as reaching it.
  assign trip    = eval && last && (cnt_nxt == CW'(THRESH));

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else if (prime) begin
      prev <= sig;
      cnt  <= '0;
    end else if (eval) begin
      prev <= sig;
      cnt  <= last ? '0 : cnt_nxt;
    end
  end

endmodule

// File: rtl/osc_window_monitor.sv
// Multi-channel windowed toggle monitor driving per-channel feedback-break enables.
module osc_window_monitor
  import osc_mon_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIN_LEN  = 16,
  parameter int THRESH   = 4,
  parameter int HOLD_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode_auto,
  input  logic                  clr,
  input  logic [NUM_CH-1:0]     sig_in,
  output logic [NUM_CH-1:0]     osc_flag,
  output logic [NUM_CH-1:0]     brk,
  output logic                  win_done,
  output logic [2:0]            state_o,
  output logic [TRIP_CNT_W-1:0] trip_cnt
);

  localparam int WIN_W  = win_cnt_w(WIN_LEN);
  localparam int HOLD_W = hold_cnt_w(HOLD_LEN);

  state_e              state, state_nxt;
  logic [WIN_W-1:0]    win_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [NUM_CH-1:0]   trip;
  logic                win_last, hold_last, abort, trip_evt, release_brk;
  logic [NUM_CH-1:0]   flag_base;
  logic [TRIP_CNT_W-1:0] tcnt_base;

  assign win_last  = (state == ST_MONITOR) && (win_cnt == WIN_W'(WIN_LEN - 1));
  assign hold_last = (state == ST_HOLD) && (hold_cnt == HOLD_W'(HOLD_LEN - 1));
  assign win_done  = win_last;
  assign state_o   = state;

  // Dropping en outranks everything else happening in the same cycle.
  assign abort       = (state != ST_IDLE) && !en;
  assign trip_evt    = win_last && (|trip) && !abort;
  assign release_brk = (hold_last && mode_auto) || ((state == ST_LOCK) && clr);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    osc_ch_counter #(.THRESH(THRESH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (!en),
      .prime (state == ST_PRIME),
      .eval  (state == ST_MONITOR),
      .last  (win_last),
      .sig   (sig_in[gi]),
      .trip  (trip[gi])
    );
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (en) state_nxt = ST_PRIME;
        ST_PRIME:   state_nxt = ST_MONITOR;
        ST_MONITOR: if (trip_evt) state_nxt = ST_HOLD;
        ST_HOLD:    if (hold_last) state_nxt = mode_auto ? ST_PRIME : ST_LOCK;
        ST_LOCK:    if (clr) state_nxt = ST_PRIME;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // A trip in the same cycle as clr re-applies on top of the cleared values.
  assign flag_base = clr ? '0 : osc_flag;
  assign tcnt_base = clr ? '0 : trip_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      win_cnt  <= '0;
      hold_cnt <= '0;
      brk      <= '0;
      osc_flag <= '0;
      trip_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        win_cnt  <= '0;
        hold_cnt <= '0;
        brk      <= '0;
      end else begin
        win_cnt  <= (state == ST_MONITOR && !win_last) ? win_cnt + WIN_W'(1) : '0;
        hold_cnt <= (state == ST_HOLD && !hold_last) ? hold_cnt + HOLD_W'(1) : '0;
        if (trip_evt) begin
          brk      <= trip;
          osc_flag <= flag_base | trip;
          trip_cnt <= (tcnt_base == '1) ? tcnt_base : tcnt_base + TRIP_CNT_W'(1);
        end else begin
          if (release_brk) brk <= '0;
          osc_flag <= flag_base;
          trip_cnt <= tcnt_base;
        end
      end
    end
  end

endmodule

// File: tb/tb_osc_window_monitor.sv
// Directed self-checking bench for osc_window_monitor (default parameters).
module tb_osc_window_monitor;

  logic       clk = 1'b0;
  logic       rst_n, en, mode_auto, clr;
  logic [3:0] sig_in, osc_flag, brk;
  logic       win_done;
  logic [2:0] state_o;
  logic [7:0] trip_cnt;
  int         tests = 0;
  int         fails = 0;
  int         pulses;

  always #5 clk = ~clk;

  osc_window_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode_auto (mode_auto),
    .clr       (clr),
    .sig_in    (sig_in),
    .osc_flag  (osc_flag),
    .brk       (brk),
    .win_done  (win_done),
    .state_o   (state_o),
    .trip_cnt  (trip_cnt)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tog(input logic [3:0] m, input int n);
    repeat (n) begin
      sig_in = sig_in ^ m;
      tick(1);
    end
  endtask

  // Leaves the DUT in MONITOR at window count 0 with prev = 0.
  task automatic start();
    en = 1'b0; sig_in = '0;
    tick(1);
    en = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode_auto = 1'b1; clr = 1'b0; sig_in = '0;
    tick(2);
    check("rst_state", state_o, 0);
    check("rst_flag", osc_flag, 0);
    check("rst_brk", brk, 0);
    check("rst_trip", trip_cnt, 0);
    check("rst_wd", win_done, 0);

    // Static inputs: no trips, win_done every 16 cycles.
    rst_n = 1'b1; en = 1'b1;
    tick(1);
    check("prime", state_o, 1);
    tick(1);
    check("monitor", state_o, 2);
    tick(15);
    check("wd_first", win_done, 1);
    pulses = 0;
    repeat (48) begin
      tick(1);
      if (win_done) pulses++;
    end
    check("wd_pulses", pulses[7:0], 3);
    check("static_flag", osc_flag, 0);
    check("static_brk", brk, 0);
    check("static_trip", trip_cnt, 0);

    // ch2 toggles every cycle, auto retry.
    start();
    tog(4'b0100, 15);
    check("t2_wd", win_done, 1);
    tog(4'b0100, 1);
    check("t2_state", state_o, 3);
    check("t2_flag", osc_flag, 4'b0100);
    check("t2_brk", brk, 4'b0100);
    check("t2_trip", trip_cnt, 1);
    tog(4'b0100, 7);
    check("t2_hold_brk", brk, 4'b0100);
    check("t2_hold_st", state_o, 3);
    tog(4'b0100, 1);
    check("t2_reprime", state_o, 1);
    check("t2_brk_rel", brk, 0);
    tog(4'b0100, 1);
    check("t2_remon", state_o, 2);
    tog(4'b0100, 16);
    check("t2_trip2", trip_cnt, 2);
    check("t2_state2", state_o, 3);

    // clr during HOLD clears flags; then 3 toggles (no trip), 4 toggles (trip).
    clr = 1'b1; tick(1); clr = 1'b0;
    check("t3_clr_flag", osc_flag, 0);
    check("t3_clr_trip", trip_cnt, 0);
    start();
    for (int k = 0; k < 16; k++) begin
      if (k == 2 || k == 5 || k == 9) sig_in[0] = ~sig_in[0];
      tick(1);
    end
    check("t3_3tog_st", state_o, 2);
    check("t3_3tog_flag", osc_flag, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == 3 || k == 7 || k == 11 || k == 15) sig_in[0] = ~sig_in[0];
      if (k == 15) check("t3_wd", win_done, 1);
      tick(1);
    end
    check("t3_4tog_st", state_o, 3);
    check("t3_4tog_flag", osc_flag, 4'b0001);
    check("t3_4tog_brk", brk, 4'b0001);
    check("t3_4tog_trip", trip_cnt, 1);

    // Lock mode on ch1.
    mode_auto = 1'b0;
    clr = 1'b1; tick(1); clr = 1'b0;
    start();
    tog(4'b0010, 16);
    check("t4_state", state_o, 3);
    check("t4_flag", osc_flag, 4'b0010);
    check("t4_brk", brk, 4'b0010);
    tick(8);
    check("t4_lock", state_o, 4);
    check("t4_lock_brk", brk, 4'b0010);
    tick(20);
    check("t4_lock_st2", state_o, 4);
    check("t4_lock_brk2", brk, 4'b0010);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("t4_clr_st", state_o, 1);
    check("t4_clr_brk", brk, 0);
    check("t4_clr_flag", osc_flag, 0);
    check("t4_clr_trip", trip_cnt, 0);
    tick(1);
    check("t4_mon", state_o, 2);

    // clr coincident with a ch3 trip: trip wins, count restarts at 1.
    mode_auto = 1'b1;
    tog(4'b1000, 16);
    check("t5_trip1", trip_cnt, 1);
    tog(4'b1000, 8);
    check("t5_prime", state_o, 1);
    tog(4'b1000, 1);
    tog(4'b1000, 15);
    clr = 1'b1;
    tog(4'b1000, 1);
    clr = 1'b0;
    check("t5_flag", osc_flag, 4'b1000);
    check("t5_trip", trip_cnt, 1);
    check("t5_state", state_o, 3);

    // Drop en mid-HOLD.
    tick(3);
    en = 1'b0;
    tick(1);
    check("t6_idle", state_o, 0);
    check("t6_brk", brk, 0);
    check("t6_flag", osc_flag, 4'b1000);
    check("t6_trip", trip_cnt, 1);

    // Reset mid-window.
    start();
    tick(5);
    rst_n = 1'b0;
    tick(1);
    check("t7_state", state_o, 0);
    check("t7_flag", osc_flag, 0);
    check("t7_brk", brk, 0);
    check("t7_trip", trip_cnt, 0);
    check("t7_wd", win_done, 0);
    rst_n = 1'b1;
    tick(1);
    check("t7_prime", state_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
